mem_bank_arbiter: RTL and testbench

Shares NUM_BANK single-port SRAM banks between NUM_PE requesters (core instr/data ports, DMA) using an OBI-style req/gnt/rvalid handshake. Decodes each requester's target bank from address bits and runs an independent round-robin arbiter per bank. Routes the 1-cycle-latency read data back to the granted requester. Sits between the PE memory ports and the SRAM bank array, and replaces the fixed-priority crossbar input stage.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/mem_bank_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_bank_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants, id types and bank decode helper for the SRAM bank arbiter.
package mem_arb_pkg;

  localparam int NUM_PE_DEF       = 4;
  localparam int NUM_BANK_DEF     = 4;
  localparam int BANK_SEL_LSB_DEF = 14;
  localparam int AW_DEF           = 32;

  typedef logic [$clog2(NUM_PE_DEF)-1:0]   pe_id_t;
  typedef logic [$clog2(NUM_BANK_DEF)-1:0] bank_id_t;

  function automatic bank_id_t bank_of(input logic [AW_DEF-1:0] addr);
    return addr[BANK_SEL_LSB_DEF +: $bits(bank_id_t)];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o
);

  int   c;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      c = (int'(ptr_i) + i) % NUM_REQ;
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/mem_bank_arbiter.sv
// Per-bank round-robin arbiter between PE memory ports and SRAM banks, fixed 1-cycle response.
// Optional stall counters are built when MEM_ARB_PERF_EN is defined.
module mem_bank_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PE       = NUM_PE_DEF,
  parameter int NUM_BANK     = NUM_BANK_DEF,
  parameter int BANK_SEL_LSB = BANK_SEL_LSB_DEF,
  parameter int AW           = AW_DEF,
  parameter int DW           = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_PE-1:0]               pe_req_i,
  input  logic [NUM_PE-1:0]               pe_we_i,
  input  logic [NUM_PE-1:0][DW/8-1:0]     pe_be_i,
  input  logic [NUM_PE-1:0][AW-1:0]       pe_addr_i,
  input  logic [NUM_PE-1:0][DW-1:0]       pe_wdata_i,
  output logic [NUM_PE-1:0]               pe_gnt_o,
  output logic [NUM_PE-1:0]               pe_rvalid_o,
  output logic [NUM_PE-1:0][DW-1:0]       pe_rdata_o,
  output logic [NUM_BANK-1:0]             bank_en_o,
  output logic [NUM_BANK-1:0]             bank_we_o,
  output logic [NUM_BANK-1:0][DW/8-1:0]   bank_be_o,
  output logic [NUM_BANK-1:0][AW-1:0]     bank_addr_o,
  output logic [NUM_BANK-1:0][DW-1:0]     bank_wdata_o,
  input  logic [NUM_BANK-1:0][DW-1:0]     bank_rdata_i,
  input  logic                            perf_clr_i,
  output logic [NUM_PE-1:0][31:0]         perf_stall_o
);

  localparam int PW = $clog2(NUM_PE);
  localparam int BW = $clog2(NUM_BANK);

  logic [NUM_PE-1:0]                 req_eff;
  logic [NUM_PE-1:0][BW-1:0]         pe_bank;
  logic [NUM_BANK-1:0][NUM_PE-1:0]   cand;
  logic [NUM_BANK-1:0][NUM_PE-1:0]   bank_gnt;
  logic [NUM_BANK-1:0][PW-1:0]       win;
  logic [NUM_BANK-1:0][PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_BANK-1:0][PW-1:0]       resp_pe_q, resp_pe_d;
  logic [NUM_BANK-1:0]               resp_vld_q, resp_vld_d;

  // Grants and bank enables must read 0 while reset is asserted, not just after it.
  assign req_eff = pe_req_i & {NUM_PE{rst_ni}};

  always_comb begin
    pe_bank = '0;
    cand    = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      pe_bank[p] = pe_addr_i[p][BANK_SEL_LSB +: BW];
    end
    for (int b = 0; b < NUM_BANK; b++) begin
      for (int p = 0; p < NUM_PE; p++) begin
        cand[b][p] = req_eff[p] && (pe_bank[p] == BW'(b));
      end
    end
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    rr_arbiter #(.NUM_REQ(NUM_PE)) u_rr (
      .req_i (cand[b]),
      .ptr_i (rr_ptr_q[b]),
      .gnt_o (bank_gnt[b]),
      .idx_o (win[b])
    );
  end

  always_comb begin
    pe_gnt_o     = '0;
    bank_en_o    = '0;
    bank_we_o    = '0;
    bank_be_o    = '0;
    bank_addr_o  = '0;
    bank_wdata_o = '0;
    rr_ptr_d     = rr_ptr_q;
    resp_vld_d   = '0;
    resp_pe_d    = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      pe_gnt_o      = pe_gnt_o | bank_gnt[b];
      resp_vld_d[b] = |cand[b];
      resp_pe_d[b]  = win[b];
      if (|cand[b]) begin
        bank_en_o[b]    = 1'b1;
        bank_we_o[b]    = pe_we_i[win[b]];
        bank_be_o[b]    = pe_be_i[win[b]];
        bank_addr_o[b]  = pe_addr_i[win[b]];
        bank_wdata_o[b] = pe_wdata_i[win[b]];
        rr_ptr_d[b]     = (win[b] == PW'(NUM_PE - 1)) ? '0 : win[b] + 1'b1;
      end else begin
        bank_addr_o[b]  = pe_addr_i[0];
        bank_wdata_o[b] = pe_wdata_i[0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      resp_vld_q <= '0;
      resp_pe_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      resp_vld_q <= resp_vld_d;
      resp_pe_q  <= resp_pe_d;
    end
  end

  // A PE has at most one outstanding response per cycle, so OR-merging is exclusive.
  always_comb begin
    pe_rvalid_o = '0;
    pe_rdata_o  = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      if (resp_vld_q[b]) begin
        pe_rvalid_o[resp_pe_q[b]] = 1'b1;
        pe_rdata_o[resp_pe_q[b]]  = pe_rdata_o[resp_pe_q[b]] | bank_rdata_i[b];
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [NUM_PE-1:0][31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    for (int p = 0; p < NUM_PE; p++) begin
      if (perf_clr_i) begin
        stall_d[p] = '0;
      end else if (req_eff[p] && !pe_gnt_o[p] && (stall_q[p] != '1)) begin
        stall_d[p] = stall_q[p] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign perf_stall_o = stall_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr_i;
  assign perf_stall_o    = '0;
`endif

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Scoreboard bench for mem_bank_arbiter: model-predicted grants/bank muxing, queued response checks.
module tb_mem_bank_arbiter;
  import mem_arb_pkg::*;

  localparam int NP = 4;
  localparam int NB = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                    clk_i = 1'b0;
  logic                    rst_ni = 1'b0;
  logic [NP-1:0]           pe_req_i;
  logic [NP-1:0]           pe_we_i;
  logic [NP-1:0][DW/8-1:0] pe_be_i;
  logic [NP-1:0][AW-1:0]   pe_addr_i;
  logic [NP-1:0][DW-1:0]   pe_wdata_i;
  logic [NP-1:0]           pe_gnt_o;
  logic [NP-1:0]           pe_rvalid_o;
  logic [NP-1:0][DW-1:0]   pe_rdata_o;
  logic [NB-1:0]           bank_en_o;
  logic [NB-1:0]           bank_we_o;
  logic [NB-1:0][DW/8-1:0] bank_be_o;
  logic [NB-1:0][AW-1:0]   bank_addr_o;
  logic [NB-1:0][DW-1:0]   bank_wdata_o;
  logic [NB-1:0][DW-1:0]   bank_rdata_i;
  logic                    perf_clr_i;
  logic [NP-1:0][31:0]     perf_stall_o;

  mem_bank_arbiter dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .pe_req_i     (pe_req_i),
    .pe_we_i      (pe_we_i),
    .pe_be_i      (pe_be_i),
    .pe_addr_i    (pe_addr_i),
    .pe_wdata_i   (pe_wdata_i),
    .pe_gnt_o     (pe_gnt_o),
    .pe_rvalid_o  (pe_rvalid_o),
    .pe_rdata_o   (pe_rdata_o),
    .bank_en_o    (bank_en_o),
    .bank_we_o    (bank_we_o),
    .bank_be_o    (bank_be_o),
    .bank_addr_o  (bank_addr_o),
    .bank_wdata_o (bank_wdata_o),
    .bank_rdata_i (bank_rdata_i),
    .perf_clr_i   (perf_clr_i),
    .perf_stall_o (perf_stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [NP-1:0]      vld;
    logic [NP-1:0][1:0] bank;
  } sb_t;

  sb_t                 sb_q[$];
  int                  n_cmp = 0;
  int                  n_err = 0;
  int                  cyc = 0;
  logic [NB-1:0][1:0]  m_ptr;
  logic [NP-1:0][31:0] m_stall;
  logic [NP-1:0]       exp_gnt;
  logic [NP-1:0]       hold;
  logic                rd_ovr_vld;
  logic [1:0]          rd_ovr_bank;
  logic [DW-1:0]       rd_ovr_data;
  logic [NP-1:0]       obs_gnt, obs_rvalid;
  logic [NB-1:0]       obs_en, obs_we;
  logic [3:0]          obs_be0;
  logic [DW-1:0]       obs_wdata0, obs_rdata0;
  logic [NP-1:0][31:0] obs_perf;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_pe(input int p, input logic req, input logic we, input logic [3:0] be,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    pe_req_i[p]   = req;
    pe_we_i[p]    = we;
    pe_be_i[p]    = be;
    pe_addr_i[p]  = addr;
    pe_wdata_i[p] = wd;
  endtask

  task automatic clear_all();
    for (int p = 0; p < NP; p++) set_pe(p, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Called at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic do_cycle();
    sb_t           e, nv;
    int            c;
    logic          found;
    logic [NB-1:0] exp_en;
    logic [NB-1:0][1:0] w;
    logic          ewe;
    logic [3:0]    ebe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    for (int b = 0; b < NB; b++) bank_rdata_i[b] = {8'hA0 + 8'(b), 24'(cyc)};
    if (rd_ovr_vld) begin
      bank_rdata_i[rd_ovr_bank] = rd_ovr_data;
      rd_ovr_vld = 1'b0;
    end
    #1;
    e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    check_val("rvalid", 64'(pe_rvalid_o), 64'(e.vld));
    for (int p = 0; p < NP; p++) begin
      check_val($sformatf("rdata%0d", p), 64'(pe_rdata_o[p]),
                e.vld[p] ? 64'(bank_rdata_i[e.bank[p]]) : 64'h0);
      check_val($sformatf("perf%0d", p), 64'(perf_stall_o[p]), 64'(m_stall[p]));
    end
    exp_gnt = '0;
    exp_en  = '0;
    w       = '0;
    for (int b = 0; b < NB; b++) begin
      found = 1'b0;
      for (int i = 0; i < NP; i++) begin
        c = (int'(m_ptr[b]) + i) % NP;
        if (!found && pe_req_i[c] && (int'(bank_of(pe_addr_i[c])) == b)) begin
          found = 1'b1;
          exp_gnt[c] = 1'b1;
          exp_en[b]  = 1'b1;
          w[b]       = 2'(c);
        end
      end
    end
    check_val("gnt", 64'(pe_gnt_o), 64'(exp_gnt));
    check_val("bank_en", 64'(bank_en_o), 64'(exp_en));
    for (int b = 0; b < NB; b++) begin
      ewe = exp_en[b] ? pe_we_i[w[b]]    : 1'b0;
      ebe = exp_en[b] ? pe_be_i[w[b]]    : 4'h0;
      ea  = exp_en[b] ? pe_addr_i[w[b]]  : pe_addr_i[0];
      ewd = exp_en[b] ? pe_wdata_i[w[b]] : pe_wdata_i[0];
      check_val($sformatf("we%0d", b), 64'(bank_we_o[b]), 64'(ewe));
      check_val($sformatf("be%0d", b), 64'(bank_be_o[b]), 64'(ebe));
      check_val($sformatf("addr%0d", b), 64'(bank_addr_o[b]), 64'(ea));
      check_val($sformatf("wdata%0d", b), 64'(bank_wdata_o[b]), 64'(ewd));
    end
    nv = '0;
    nv.vld = exp_gnt;
    for (int p = 0; p < NP; p++) nv.bank[p] = bank_of(pe_addr_i[p]);
    sb_q.push_back(nv);
    for (int b = 0; b < NB; b++) if (exp_en[b]) m_ptr[b] = 2'((int'(w[b]) + 1) % NP);
`ifdef MEM_ARB_PERF_EN
    for (int p = 0; p < NP; p++) begin
      if (perf_clr_i) m_stall[p] = '0;
      else if (pe_req_i[p] && !exp_gnt[p] && m_stall[p] != 32'hFFFF_FFFF) m_stall[p] = m_stall[p] + 1;
    end
`endif
    obs_gnt    = pe_gnt_o;
    obs_rvalid = pe_rvalid_o;
    obs_en     = bank_en_o;
    obs_we     = bank_we_o;
    obs_be0    = bank_be_o[0];
    obs_wdata0 = bank_wdata_o[0];
    obs_rdata0 = pe_rdata_o[0];
    obs_perf   = perf_stall_o;
    cyc++;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    m_ptr = '0;
    m_stall = '0;
    hold = '0;
    rd_ovr_vld = 1'b0;
    rd_ovr_bank = '0;
    rd_ovr_data = '0;
    perf_clr_i = 1'b0;
    bank_rdata_i = '0;
    clear_all();
    for (int p = 0; p < NP; p++) set_pe(p, 1'b1, 1'b1, 4'hF, 32'h0, 32'h0);
    #3;
    check_val("rst_gnt", 64'(pe_gnt_o), 64'h0);
    check_val("rst_en", 64'(bank_en_o), 64'h0);
    check_val("rst_we", 64'(bank_we_o), 64'h0);
    check_val("rst_rvalid", 64'(pe_rvalid_o), 64'h0);
    check_val("rst_perf", 64'(perf_stall_o[0] | perf_stall_o[3]), 64'h0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    clear_all();
    rst_ni = 1'b1;
    do_cycle();

    // single read to bank 2
    set_pe(0, 1'b1, 1'b0, 4'hF, 32'h0000_8000, 32'h0);
    do_cycle();
    check_val("rd_gnt", 64'(obs_gnt), 64'b0001);
    check_val("rd_en", 64'(obs_en), 64'b0100);
    check_val("rd_we2", 64'(obs_we[2]), 64'h0);
    clear_all();
    rd_ovr_vld = 1'b1; rd_ovr_bank = 2'd2; rd_ovr_data = 32'hDEAD_BEEF;
    do_cycle();
    check_val("rd_rvalid", 64'(obs_rvalid), 64'b0001);
    check_val("rd_rdata", 64'(obs_rdata0), 64'hDEAD_BEEF);

    perf_clr_i = 1'b1;
    do_cycle();
    perf_clr_i = 1'b0;

    // four-way contention on bank 1 starting from pointer 0
    for (int p = 0; p < NP; p++) set_pe(p, 1'b1, 1'b0, 4'hF, 32'h0000_4000 + 32'(p * 4), 32'h0);
    for (int k = 0; k < NP; k++) begin
      do_cycle();
      check_val($sformatf("cont_gnt%0d", k), 64'(obs_gnt), 64'(1 << k));
      set_pe(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    end
    do_cycle();
    check_val("cont_last_rvalid", 64'(obs_rvalid), 64'b1000);
`ifdef MEM_ARB_PERF_EN
    check_val("perf_pe3", 64'(obs_perf[3]), 64'd3);
    check_val("perf_pe0", 64'(obs_perf[0]), 64'd0);
`endif
    set_pe(0, 1'b1, 1'b0, 4'hF, 32'h0000_4100, 32'h0);
    set_pe(2, 1'b1, 1'b0, 4'hF, 32'h0000_4200, 32'h0);
    do_cycle();
    check_val("ptr1_wrap", 64'(obs_gnt), 64'b0001);
    set_pe(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    do_cycle();
    check_val("ptr1_next", 64'(obs_gnt), 64'b0100);
    clear_all();
    perf_clr_i = 1'b1;
    do_cycle();
    perf_clr_i = 1'b0;
    do_cycle();
    check_val("perf_clr", 64'(obs_perf[0] | obs_perf[1] | obs_perf[2] | obs_perf[3]), 64'h0);

    // independent banks in the same cycle
    set_pe(0, 1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    set_pe(1, 1'b1, 1'b0, 4'hF, 32'h0000_4010, 32'h0);
    set_pe(2, 1'b1, 1'b1, 4'h5, 32'h0000_C010, 32'h5555_AAAA);
    do_cycle();
    check_val("par_gnt", 64'(obs_gnt), 64'b0111);
    check_val("par_en", 64'(obs_en), 64'b1011);
    clear_all();

    // partial write to bank 0
    set_pe(3, 1'b1, 1'b1, 4'b0011, 32'h0000_0020, 32'h1234_5678);
    do_cycle();
    check_val("wr_we0", 64'(obs_we[0]), 64'h1);
    check_val("wr_be0", 64'(obs_be0), 64'b0011);
    check_val("wr_wdata0", 64'(obs_wdata0), 64'h1234_5678);
    clear_all();
    do_cycle();
    check_val("wr_rvalid", 64'(obs_rvalid), 64'b1000);

    // random traffic; a request is held until granted
    for (int n = 0; n < 60; n++) begin
      for (int p = 0; p < NP; p++) begin
        if (!hold[p]) begin
          set_pe(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                 $urandom, $urandom);
        end
      end
      do_cycle();
      hold = pe_req_i & ~exp_gnt;
    end
    clear_all();
    do_cycle();

    // reset in the cycle after a grant
    set_pe(1, 1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0);
    do_cycle();
    check_val("pre_rst_gnt", 64'(obs_gnt), 64'b0010);
    rst_ni = 1'b0;
    for (int p = 1; p < NP; p++) set_pe(p, 1'b1, 1'b0, 4'hF, 32'h0000_0040 + 32'(p), 32'h0);
    #1;
    check_val("midrst_gnt", 64'(pe_gnt_o), 64'h0);
    check_val("midrst_en", 64'(bank_en_o), 64'h0);
    check_val("midrst_rvalid", 64'(pe_rvalid_o), 64'h0);
    sb_q.delete();
    m_ptr = '0;
    m_stall = '0;
    @(posedge clk_i);
    #1;
    check_val("midrst_rvalid2", 64'(pe_rvalid_o), 64'h0);
    rst_ni = 1'b1;
    do_cycle();
    check_val("post_rst_gnt", 64'(obs_gnt), 64'b0010);
    clear_all();
    do_cycle();
    do_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
